// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the MEM-stage data-memory controller.
// Holds the controller FSM encoding, RISC-V load/store funct3 codes and the
// byte-lane helper functions used by mod_dmem_ctrl and mod_load_ext.
package dmem_pkg;

   localparam int BE_WIDTH = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   // Access size from funct3; anything not byte/half is a word access.
   function automatic size_t f3_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: f3_size = SZ_BYTE;
         F3_H, F3_HU: f3_size = SZ_HALF;
         default:     f3_size = SZ_WORD;
      endcase
   endfunction

   // Byte enables; low offset bits beyond the access size are ignored.
   function automatic logic [BE_WIDTH-1:0] calc_be(input logic [2:0] funct3,
                                                   input logic [1:0] off);
      case (f3_size(funct3))
         SZ_BYTE: calc_be = 4'b0001 << off;
         SZ_HALF: calc_be = off[1] ? 4'b1100 : 4'b0011;
         default: calc_be = 4'b1111;
      endcase
   endfunction

   // Replicate store data across all lanes so the byte enables pick the slot.
   function automatic logic [31:0] steer_wdata(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
      case (f3_size(funct3))
         SZ_BYTE: steer_wdata = {4{wdata[7:0]}};
         SZ_HALF: steer_wdata = {2{wdata[15:0]}};
         default: steer_wdata = wdata;
      endcase
   endfunction

   // Halfwords must be 2-byte aligned, words 4-byte aligned.
   function automatic logic is_misaligned(input logic [2:0] funct3,
                                          input logic [1:0] off);
      case (f3_size(funct3))
         SZ_BYTE: is_misaligned = 1'b0;
         SZ_HALF: is_misaligned = off[0];
         default: is_misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mod_dmem_ctrl_load_ext.sv
// mod_load_ext: selects the addressed byte/half from a bus read word and
// sign- or zero-extends it (funct3[2] set = unsigned load).
module mod_load_ext
   import dmem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_funct3,
   input  logic [1:0]      i_off,
   input  logic [XLEN-1:0] i_rdata,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_signed;

   assign w_byte   = i_rdata[{i_off, 3'b000} +: 8];
   assign w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   assign w_signed = ~i_funct3[2];

   // Lane select and extension by access size.
   always_comb begin
      o_data = i_rdata;
      case (f3_size(i_funct3))
         SZ_BYTE: o_data = {{(XLEN-8){w_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{(XLEN-16){w_signed & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mod_dmem_ctrl.sv
// mod_dmem_ctrl: MEM-stage data-memory controller. Converts load/store
// requests into a req/gnt/rvalid word bus and stalls the pipeline until the
// access completes. Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned
// accesses skip the bus and pulse misalign_o instead of being truncated.
module mod_dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                mem_read_en_i,
   input  logic                mem_write_en_i,
   input  logic [2:0]          funct3_i,
   input  logic [XLEN-1:0]     addr_i,
   input  logic [XLEN-1:0]     wdata_i,
   output logic [XLEN-1:0]     mem_read_o,
   output logic                stall_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [BE_WIDTH-1:0] bus_be_o,
   output logic [XLEN-1:0]     bus_addr_o,
   output logic [XLEN-1:0]     bus_wdata_o,
   input  logic                bus_gnt_i,
   input  logic                bus_rvalid_i,
   input  logic [XLEN-1:0]     bus_rdata_i
`ifdef DMEM_MISALIGN_TRAP_EN
   ,
   output logic                misalign_o
`endif
);

   state_t              r_state;
   state_t              w_next;
   logic                w_access;
   logic                w_trap;
   logic                w_stall;
   logic                w_req;
   logic                r_we;
   logic [BE_WIDTH-1:0] r_be;
   logic [XLEN-1:0]     r_addr;
   logic [XLEN-1:0]     r_wdata;
   logic [2:0]          r_funct3;
   logic [1:0]          r_off;
   logic [XLEN-1:0]     r_rdata;
   logic [XLEN-1:0]     w_load;

   assign w_access = mem_read_en_i | mem_write_en_i;

`ifdef DMEM_MISALIGN_TRAP_EN
   logic r_misalign;
   assign w_trap     = w_access & is_misaligned(funct3_i, addr_i[1:0]);
   assign misalign_o = r_misalign;
`else
   assign w_trap = 1'b0;
`endif

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state, stall and request decode.
   always_comb begin
      w_next  = r_state;
      w_stall = 1'b0;
      w_req   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_access) begin
               w_stall = 1'b1;
               w_next  = w_trap ? ST_DONE : ST_REQ;
            end
         end
         ST_REQ: begin
            w_stall = 1'b1;
            w_req   = 1'b1;
            if (bus_gnt_i) w_next = r_we ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            w_stall = 1'b1;
            if (bus_rvalid_i) w_next = ST_DONE;
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // Latch the access attributes once in IDLE so the bus sees stable values.
   // A simultaneous read and write enable is treated as a write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_we     <= 1'b0;
         r_be     <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_funct3 <= '0;
         r_off    <= '0;
      end else if (r_state == ST_IDLE && w_access) begin
         r_we     <= mem_write_en_i;
         r_be     <= calc_be(funct3_i, addr_i[1:0]);
         r_addr   <= {addr_i[XLEN-1:2], 2'b00};
         r_wdata  <= steer_wdata(funct3_i, wdata_i);
         r_funct3 <= funct3_i;
         r_off    <= addr_i[1:0];
      end
   end

   mod_load_ext #(
      .XLEN(XLEN)
   ) u_load_ext (
      .i_funct3(r_funct3),
      .i_off   (r_off),
      .i_rdata (bus_rdata_i),
      .o_data  (w_load)
   );

   // Load result register: updated only by a completed read.
   always_ff @(posedge clk_i) begin
      if (rst_i)                                    r_rdata <= '0;
      else if (r_state == ST_WAIT && bus_rvalid_i)  r_rdata <= w_load;
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   // Trap flag set on the IDLE->DONE hop so it is high exactly during DONE.
   always_ff @(posedge clk_i) begin
      if (rst_i) r_misalign <= 1'b0;
      else       r_misalign <= (r_state == ST_IDLE) & w_trap;
   end
`endif

   assign stall_o     = w_stall;
   assign bus_req_o   = w_req;
   assign bus_we_o    = r_we;
   assign bus_be_o    = r_be;
   assign bus_addr_o  = r_addr;
   assign bus_wdata_o = r_wdata;
   assign mem_read_o  = r_rdata;

endmodule

// File: doc/mod_dmem_ctrl.md
Name: mod_dmem_ctrl

Overview:
- Data-memory access controller for the MEM stage. It drives load data and the pipeline stall into the MEM/WB register.
- Turns load/store requests from EX/MEM into a req/gnt/rvalid word bus, with byte-lane steering and load sign/zero extension.
- Holds stall_o high until each access completes, so the whole pipeline freezes during multi-cycle memory latency.

Parameters:
- XLEN, 32, data/address width; fixed at 32 because the bus has 4 byte enables.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- mem_read_en_i  in  1  load in MEM stage
- mem_write_en_i  in  1  store in MEM stage
- funct3_i  in  3  load/store size and sign
- addr_i  in  XLEN  byte address (ALU result)
- wdata_i  in  XLEN  store data (rs2)
- mem_read_o  out  XLEN  extended load data to MEM/WB
- stall_o  out  1  pipeline stall
- bus_req_o  out  1  bus request
- bus_we_o  out  1  write enable
- bus_be_o  out  4  byte enables
- bus_addr_o  out  XLEN  word-aligned address
- bus_wdata_o  out  XLEN  lane-steered write data
- bus_gnt_i  in  1  request accepted
- bus_rvalid_i  in  1  read data valid
- bus_rdata_i  in  XLEN  read word

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Reset mid-access abandons the transaction; bus_req_o is 0 from the next cycle.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Access = mem_read_en_i | mem_write_en_i.
  - On access, register we, be, aligned addr, steered wdata, funct3 and addr[1:0]; go to REQ.
  - If both enables are high, the write wins and the read is ignored.
- REQ:
  - bus_req_o=1; bus_we/be/addr/wdata are stable from registers.
  - When bus_gnt_i=1: a write goes to DONE, a read goes to WAIT.
  - bus_rvalid_i is ignored in REQ.
- WAIT: on bus_rvalid_i, capture the extended load into mem_read_o and go to DONE. rvalid earliest arrives one cycle after gnt.
- DONE: one cycle, then unconditionally to IDLE. The pipeline advances at the end of this cycle, so the same access is never reissued.
- stall_o is combinational: (IDLE & access) | REQ | WAIT. It is 0 in DONE and in IDLE with no access.
- Minimum latency: a read with immediate gnt and next-cycle rvalid takes 3 stall cycles; a write with immediate gnt takes 2.
- mem_read_o holds its value until the next completed load. Stores do not change it.
- Lane rules, with off = addr[1:0]:
  - bus_addr_o = {addr[31:2],2'b00}.
  - SB (000): be = 0001<<off; wdata = byte replicated ×4.
  - SH (001): be = 0011<<(off[1]*2); wdata = half replicated ×2.
  - SW (010): be = 1111.
  - LB/LBU (000/100): byte selected by off, then sign/zero-extended.
  - LH/LHU (001/101): half selected by off[1], then extended.
  - LW (010): full word.
- Unlisted funct3 values are treated as word access.
- Misalignment: SH/LH with off[0]=1, or SW/LW with off≠0.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output port misalign_o (1 bit, reset 0).
  - A misaligned access issues no bus request; the FSM goes IDLE→DONE.
  - misalign_o pulses high in DONE.
  - mem_read_o is left unchanged.
- Disabled:
  - No port.
  - Misaligned accesses are issued using the aligned lane rules above: low address bits are truncated to the access size.

Decomposition:
- Package dmem_pkg holds:
  - the FSM state enum;
  - funct3 localparams: F3_B/H/W/BU/HU;
  - the BE_WIDTH=4 constant;
  - a function computing byte enables from funct3 and offset.
- Sub-module mod_load_ext: combinational lane select plus sign/zero extension (funct3, offset, rdata → XLEN).

Test Plan:
- LW at addr 0x100, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF:
  - bus_addr 0x100, be 1111;
  - stall high 3 cycles;
  - mem_read_o = 0xDEADBEEF in DONE.
- LB at 0x103, rdata 0x80FFFFFF → mem_read_o 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x102 with wdata 0x0000ABCD, gnt delayed 4 cycles:
  - bus_req held 4 cycles;
  - be 1100, bus_wdata 0xABCDABCD;
  - stall drops in DONE.
- mem_read_en and mem_write_en both high at 0x10: write issued (we=1), no WAIT state, mem_read_o unchanged.
- rst_i asserted in WAIT, then rvalid with 0x12345678: FSM in IDLE, bus_req 0, stall 0, mem_read_o stays 0.
- With DMEM_MISALIGN_TRAP_EN defined, LW at 0x101: no bus_req; misalign_o pulses for 1 cycle; 1 stall cycle.
